// File: rtl/alu_arbiter_if.sv
// Command/response channels of the two ALU requesters plus the shared ALU bus.
// The per-requester error flags exist only when ALU_ILLEGAL_OP_CHECK_EN is defined.
interface alu_arbiter_if #(
  parameter int BITS  = 8,
  parameter int ALUOP = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [ALUOP-1:0] req0_func;
  logic [BITS-1:0]  req0_a;
  logic [BITS-1:0]  req0_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [BITS-1:0]  rsp0_result;
  logic             req1_valid;
  logic             req1_ready;
  logic [ALUOP-1:0] req1_func;
  logic [BITS-1:0]  req1_a;
  logic [BITS-1:0]  req1_b;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [BITS-1:0]  rsp1_result;
  logic [ALUOP-1:0] alu_function;
  logic [BITS-1:0]  alu_a;
  logic [BITS-1:0]  alu_b;
  logic [BITS-1:0]  alu_result;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  logic             rsp0_err;
  logic             rsp1_err;
`endif

  modport slave (
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    output rsp0_err, output rsp1_err,
`endif
    input  req0_valid, req0_func, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_func, req1_a, req1_b, rsp1_ready,
    input  alu_result,
    output req0_ready, rsp0_valid, rsp0_result,
    output req1_ready, rsp1_valid, rsp1_result,
    output alu_function, alu_a, alu_b
  );

  modport master (
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    input  rsp0_err, input rsp1_err,
`endif
    output req0_valid, req0_func, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_func, req1_a, req1_b, rsp1_ready,
    output alu_result,
    input  req0_ready, rsp0_valid, rsp0_result,
    input  req1_ready, rsp1_valid, rsp1_result,
    input  alu_function, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters (IDLE -> ISSUE -> RESP).
// Define ALU_ILLEGAL_OP_CHECK_EN to short-circuit illegal function codes with an error response.
module alu_arbiter #(
  parameter int BITS  = 8,
  parameter int ALUOP = 4
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           stateNext_s;
  logic             busy_r;
  logic             lastGrant_r;
  logic             owner_r;
  logic [ALUOP-1:0] aluFunc_r;
  logic [BITS-1:0]  aluA_r;
  logic [BITS-1:0]  aluB_r;
  logic             rsp0Valid_r;
  logic             rsp1Valid_r;
  logic [BITS-1:0]  rsp0Result_r;
  logic [BITS-1:0]  rsp1Result_r;

  logic             grantValid_s;
  logic             winner_s;
  logic             ownerReady_s;
  logic             skipIssue_s;
  logic [ALUOP-1:0] winFunc_s;
  logic [BITS-1:0]  winA_s;
  logic [BITS-1:0]  winB_s;

`ifdef ALU_ILLEGAL_OP_CHECK_EN
  logic rsp0Err_r;
  logic rsp1Err_r;

  function automatic logic isIllegalOp(input logic [ALUOP-1:0] func);
    return (func == {ALUOP{1'b0}}) || (func > ALUOP'(4'd9));
  endfunction
`endif

  // Round-robin winner selection; only meaningful while idle.
  always_comb begin
    winner_s     = 1'b0;
    grantValid_s = 1'b0;
    if (state_r == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        winner_s     = ~lastGrant_r;
        grantValid_s = 1'b1;
      end else if (bus.req0_valid) begin
        winner_s     = 1'b0;
        grantValid_s = 1'b1;
      end else if (bus.req1_valid) begin
        winner_s     = 1'b1;
        grantValid_s = 1'b1;
      end else begin
        winner_s     = 1'b0;
        grantValid_s = 1'b0;
      end
    end else begin
      winner_s     = 1'b0;
      grantValid_s = 1'b0;
    end
  end

  assign winFunc_s    = winner_s ? bus.req1_func : bus.req0_func;
  assign winA_s       = winner_s ? bus.req1_a : bus.req0_a;
  assign winB_s       = winner_s ? bus.req1_b : bus.req0_b;
  assign ownerReady_s = owner_r ? bus.rsp1_ready : bus.rsp0_ready;

`ifdef ALU_ILLEGAL_OP_CHECK_EN
  assign skipIssue_s = isIllegalOp(winFunc_s);
`else
  assign skipIssue_s = 1'b0;
`endif

  // Next-state logic of the arbitration FSM.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (grantValid_s) begin
          if (skipIssue_s) begin
            stateNext_s = RESP;
          end else begin
            stateNext_s = ISSUE;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      ISSUE: stateNext_s = RESP;
      RESP: begin
        if (ownerReady_s) begin
          stateNext_s = IDLE;
        end else begin
          stateNext_s = RESP;
        end
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // State register; busy is registered from the next state so it tracks state_r exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      busy_r  <= (stateNext_s != IDLE);
    end
  end

  // Operand latch, result capture and response-valid handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant_r  <= 1'b1;
      owner_r      <= 1'b0;
      aluFunc_r    <= {ALUOP{1'b0}};
      aluA_r       <= {BITS{1'b0}};
      aluB_r       <= {BITS{1'b0}};
      rsp0Valid_r  <= 1'b0;
      rsp1Valid_r  <= 1'b0;
      rsp0Result_r <= {BITS{1'b0}};
      rsp1Result_r <= {BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grantValid_s) begin
            owner_r     <= winner_s;
            lastGrant_r <= winner_s;
            if (skipIssue_s) begin
              // Illegal code: the ALU stays at "no function" and a zero result is posted at once.
              aluFunc_r <= {ALUOP{1'b0}};
              aluA_r    <= {BITS{1'b0}};
              aluB_r    <= {BITS{1'b0}};
              if (winner_s) begin
                rsp1Valid_r  <= 1'b1;
                rsp1Result_r <= {BITS{1'b0}};
              end else begin
                rsp0Valid_r  <= 1'b1;
                rsp0Result_r <= {BITS{1'b0}};
              end
            end else begin
              aluFunc_r <= winFunc_s;
              aluA_r    <= winA_s;
              aluB_r    <= winB_s;
            end
          end
        end
        ISSUE: begin
          aluFunc_r <= {ALUOP{1'b0}};
          aluA_r    <= {BITS{1'b0}};
          aluB_r    <= {BITS{1'b0}};
          if (owner_r) begin
            rsp1Valid_r  <= 1'b1;
            rsp1Result_r <= bus.alu_result;
          end else begin
            rsp0Valid_r  <= 1'b1;
            rsp0Result_r <= bus.alu_result;
          end
        end
        RESP: begin
          if (ownerReady_s) begin
            if (owner_r) begin
              rsp1Valid_r <= 1'b0;
            end else begin
              rsp0Valid_r <= 1'b0;
            end
          end
        end
        default: begin
          aluFunc_r <= {ALUOP{1'b0}};
        end
      endcase
    end
  end

`ifdef ALU_ILLEGAL_OP_CHECK_EN
  // Error flag follows the owner's accepted command and is held with its result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0Err_r <= 1'b0;
      rsp1Err_r <= 1'b0;
    end else if (state_r == IDLE && grantValid_s) begin
      if (winner_s) begin
        rsp1Err_r <= skipIssue_s;
      end else begin
        rsp0Err_r <= skipIssue_s;
      end
    end
  end

  assign bus.rsp0_err = rsp0Err_r;
  assign bus.rsp1_err = rsp1Err_r;
`endif

  assign bus.req0_ready   = grantValid_s & ~winner_s;
  assign bus.req1_ready   = grantValid_s & winner_s;
  assign bus.rsp0_valid   = rsp0Valid_r;
  assign bus.rsp1_valid   = rsp1Valid_r;
  assign bus.rsp0_result  = rsp0Result_r;
  assign bus.rsp1_result  = rsp1Result_r;
  assign bus.alu_function = aluFunc_r;
  assign bus.alu_a        = aluA_r;
  assign bus.alu_b        = aluB_r;
  assign busy             = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
// The bench supplies the ALU itself; outputs are sampled on the falling clock edge.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   vecs = 0;
  int   errs = 0;

  alu_arbiter_if #(.BITS(8), .ALUOP(4)) bus ();

  alu_arbiter #(.BITS(8), .ALUOP(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: 8-bit ops, shift/rotate amount taken from operand B.
  function automatic logic [7:0] aluRef(input int f, input int a, input int b);
    int s;
    int r;
    s = b % 8;
    case (f)
      1: r = a + b;
      2: r = a - b;
      3: r = a ^ b;
      4: r = a & b;
      5: r = a | b;
      6: r = a << b;
      7: r = a >> b;
      8: r = (a << s) | (a >> (8 - s));
      9: r = (a >> s) | (a << (8 - s));
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  always_comb bus.alu_result = aluRef(int'(bus.alu_function), int'(bus.alu_a), int'(bus.alu_b));

  task automatic drive0(input bit v, input int f, input int a, input int b);
    bus.req0_valid = v; bus.req0_func = 4'(f); bus.req0_a = 8'(a); bus.req0_b = 8'(b);
  endtask

  task automatic drive1(input bit v, input int f, input int a, input int b);
    bus.req1_valid = v; bus.req1_func = 4'(f); bus.req1_a = 8'(a); bus.req1_b = 8'(b);
  endtask

  task automatic doReset();
    reset = 1'b1;
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a falling edge; returns just before the accepting rising edge.
  task automatic waitReady(input int who, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if ((who == 0 && bus.req0_ready) || (who == 1 && bus.req1_ready)) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    doReset();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vecs++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid: got %b%b want 00", bus.rsp0_valid, bus.rsp1_valid); end
    vecs++; if (bus.rsp0_result !== 8'd0 || bus.rsp1_result !== 8'd0) begin errs++; $display("FAIL reset_rsp_result: got %h %h want 00 00", bus.rsp0_result, bus.rsp1_result); end
    vecs++; if (bus.alu_function !== 4'd0 || bus.alu_a !== 8'd0 || bus.alu_b !== 8'd0) begin errs++; $display("FAIL reset_alu_bus: got %h %h %h want 0 0 0", bus.alu_function, bus.alu_a, bus.alu_b); end
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    vecs++; if (bus.rsp0_err !== 1'b0 || bus.rsp1_err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b%b want 00", bus.rsp0_err, bus.rsp1_err); end
`endif
    drive0(1'b1, 1, 1, 1);
    drive1(1'b1, 1, 1, 1);
    #1;
    vecs++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errs++; $display("FAIL reset_first_grant: got r0=%b r1=%b want r0=1 r1=0", bus.req0_ready, bus.req1_ready); end
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
    #1;
    vecs++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin errs++; $display("FAIL reset_idle_ready: got r0=%b r1=%b want 00", bus.req0_ready, bus.req1_ready); end
  endtask

  task automatic test_add_wrap();
    bit ok;
    doReset();
    bus.rsp0_ready = 1'b1;
    drive0(1'b1, 1, 200, 100);
    waitReady(0, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL add_accept: ready timeout"); end
    @(negedge clk);
    drive0(1'b0, 0, 0, 0);
    vecs++; if (busy !== 1'b1 || bus.rsp0_valid !== 1'b0) begin errs++; $display("FAIL add_issue: busy=%b valid=%b want 1 0", busy, bus.rsp0_valid); end
    vecs++; if (bus.alu_function !== 4'd1 || bus.alu_a !== 8'd200 || bus.alu_b !== 8'd100) begin errs++; $display("FAIL add_alu_bus: got %0d %0d %0d want 1 200 100", bus.alu_function, bus.alu_a, bus.alu_b); end
    @(negedge clk);
    vecs++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 8'd44) begin errs++; $display("FAIL add_result: valid=%b result=%0d want 1 44", bus.rsp0_valid, bus.rsp0_result); end
    vecs++; if (busy !== 1'b1 || bus.alu_function !== 4'd0 || bus.alu_a !== 8'd0) begin errs++; $display("FAIL add_resp_state: busy=%b func=%0d a=%0d want 1 0 0", busy, bus.alu_function, bus.alu_a); end
    @(negedge clk);
    vecs++; if (busy !== 1'b0 || bus.rsp0_valid !== 1'b0 || bus.rsp0_result !== 8'd44) begin errs++; $display("FAIL add_done: busy=%b valid=%b result=%0d want 0 0 44", busy, bus.rsp0_valid, bus.rsp0_result); end
  endtask

  task automatic test_simultaneous();
    int f0[2] = '{2, 1};   int a0[2] = '{10, 5};    int b0[2] = '{3, 6};
    int f1[2] = '{3, 5};   int a1[2] = '{'hF0, 'h0F}; int b1[2] = '{'h3C, 'h30};
    int expOwner[4] = '{0, 1, 0, 1};
    int expRes[4] = '{7, 'hCC, 11, 'h3F};
    int gotOwner[4];
    int gotRes[4];
    int idx0 = 0;
    int idx1 = 0;
    int nResp = 0;
    doReset();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nResp < 4; cyc++) begin
      drive0(idx0 < 2, f0[idx0 % 2], a0[idx0 % 2], b0[idx0 % 2]);
      drive1(idx1 < 2, f1[idx1 % 2], a1[idx1 % 2], b1[idx1 % 2]);
      if (bus.rsp0_valid) begin gotOwner[nResp] = 0; gotRes[nResp] = int'(bus.rsp0_result); nResp++; end
      else if (bus.rsp1_valid) begin gotOwner[nResp] = 1; gotRes[nResp] = int'(bus.rsp1_result); nResp++; end
      #1;
      if (bus.req0_ready) idx0++;
      if (bus.req1_ready) idx1++;
      @(negedge clk);
    end
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
    vecs++; if (nResp != 4) begin errs++; $display("FAIL simul_count: got %0d responses want 4", nResp); end
    for (int i = 0; i < nResp; i++) begin
      vecs++;
      if (gotOwner[i] != expOwner[i] || gotRes[i] != expRes[i]) begin
        errs++; $display("FAIL simul_order[%0d]: got req%0d=%h want req%0d=%h", i, gotOwner[i], gotRes[i], expOwner[i], expRes[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_rotate();
    int fs[2] = '{8, 9};
    int ex[2] = '{'h8D, 'h36};
    bit ok;
    doReset();
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive1(1'b1, fs[i], 'hB1, 3);
      waitReady(1, ok);
      vecs++; if (!ok) begin errs++; $display("FAIL rot_accept[%0d]: ready timeout", i); end
      @(negedge clk);
      drive1(1'b0, 0, 0, 0);
      @(negedge clk);
      vecs++; if (bus.rsp1_valid !== 1'b1 || int'(bus.rsp1_result) != ex[i]) begin errs++; $display("FAIL rot_result[%0d]: valid=%b result=%h want 1 %h", i, bus.rsp1_valid, bus.rsp1_result, ex[i]); end
      vecs++; if (bus.rsp0_valid !== 1'b0) begin errs++; $display("FAIL rot_nonowner[%0d]: rsp0_valid=%b want 0", i, bus.rsp0_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    doReset();
    bus.rsp1_ready = 1'b1;
    drive0(1'b1, 1, 1, 1);
    waitReady(0, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL bp_accept: ready timeout"); end
    @(negedge clk);
    drive0(1'b0, 0, 0, 0);
    drive1(1'b1, 1, 2, 3);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      vecs++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 8'd2) begin errs++; $display("FAIL bp_hold[%0d]: valid=%b result=%0d want 1 2", i, bus.rsp0_valid, bus.rsp0_result); end
      #1;
      vecs++; if (bus.req1_ready !== 1'b0) begin errs++; $display("FAIL bp_req1_blocked[%0d]: ready=%b want 0", i, bus.req1_ready); end
      @(negedge clk);
    end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    vecs++; if (bus.rsp0_valid !== 1'b0 || bus.rsp0_result !== 8'd2) begin errs++; $display("FAIL bp_release: valid=%b result=%0d want 0 2", bus.rsp0_valid, bus.rsp0_result); end
    #1;
    vecs++; if (bus.req1_ready !== 1'b1) begin errs++; $display("FAIL bp_req1_grant: ready=%b want 1", bus.req1_ready); end
    @(negedge clk);
    drive1(1'b0, 0, 0, 0);
    @(negedge clk);
    vecs++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 8'd5) begin errs++; $display("FAIL bp_req1_result: valid=%b result=%0d want 1 5", bus.rsp1_valid, bus.rsp1_result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    bit sawValid = 1'b0;
    doReset();
    bus.rsp0_ready = 1'b1;
    drive0(1'b1, 3, 'hAA, 'h55);
    waitReady(0, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL rst_accept: ready timeout"); end
    @(negedge clk);
    drive0(1'b0, 0, 0, 0);
    vecs++; if (busy !== 1'b1 || bus.alu_function !== 4'd3) begin errs++; $display("FAIL rst_in_issue: busy=%b func=%0d want 1 3", busy, bus.alu_function); end
    #2;
    reset = 1'b1;
    #1;
    vecs++; if (busy !== 1'b0 || bus.alu_function !== 4'd0 || bus.alu_a !== 8'd0 || bus.alu_b !== 8'd0) begin errs++; $display("FAIL rst_async: busy=%b func=%0d a=%0d b=%0d want all 0", busy, bus.alu_function, bus.alu_a, bus.alu_b); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.rsp0_valid || bus.rsp1_valid || busy) sawValid = 1'b1;
      @(negedge clk);
    end
    vecs++; if (sawValid) begin errs++; $display("FAIL rst_no_response: activity seen after reset, want none"); end
    vecs++; if (bus.rsp0_result !== 8'd0) begin errs++; $display("FAIL rst_result: got %h want 00", bus.rsp0_result); end
  endtask

`ifdef ALU_ILLEGAL_OP_CHECK_EN
  task automatic test_illegal_op();
    bit ok;
    doReset();
    bus.rsp0_ready = 1'b1;
    drive0(1'b1, 12, 'h11, 'h22);
    waitReady(0, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL ill_accept: ready timeout"); end
    @(negedge clk);
    drive0(1'b0, 0, 0, 0);
    vecs++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 8'd0 || bus.rsp0_err !== 1'b1) begin errs++; $display("FAIL ill_resp: valid=%b result=%h err=%b want 1 00 1", bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err); end
    vecs++; if (bus.alu_function !== 4'd0) begin errs++; $display("FAIL ill_alu_func: got %0d want 0", bus.alu_function); end
    @(negedge clk);
    drive0(1'b1, 4, 'hF0, 'h3C);
    waitReady(0, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL ill_next_accept: ready timeout"); end
    @(negedge clk);
    drive0(1'b0, 0, 0, 0);
    @(negedge clk);
    vecs++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 8'h30 || bus.rsp0_err !== 1'b0) begin errs++; $display("FAIL ill_legal_after: valid=%b result=%h err=%b want 1 30 0", bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err); end
    @(negedge clk);
  endtask
`endif

  // Random traffic; the model tracks arbitration, latency and held results from the rules alone.
  task automatic test_random();
    bit   mBusy = 1'b0;
    bit   mIllegal = 1'b0;
    int   mOwner = 0, mAge = 0, mLast = 1;
    int   mFunc = 0, mA = 0, mB = 0;
    logic [7:0] mRes = 8'd0;
    logic [7:0] lastRes[2];
    bit   v[2], rr[2], vis, anyWin;
    int   f[2], a[2], b[2];
    int   winner, eF, eA, eB;
    doReset();
    lastRes[0] = 8'd0; lastRes[1] = 8'd0;
    v[0] = 1'b0; v[1] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      vis = mBusy && (mAge >= (mIllegal ? 0 : 1));
      if (vis) lastRes[mOwner] = mRes;
      vecs++; if (busy !== mBusy) begin errs++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, mBusy); end
      vecs++; if (bus.rsp0_valid !== (vis && mOwner == 0) || bus.rsp1_valid !== (vis && mOwner == 1)) begin errs++; $display("FAIL rnd_valid@%0d: got %b%b want %b%b", cyc, bus.rsp1_valid, bus.rsp0_valid, vis && mOwner == 1, vis && mOwner == 0); end
      vecs++; if (bus.rsp0_result !== lastRes[0] || bus.rsp1_result !== lastRes[1]) begin errs++; $display("FAIL rnd_result@%0d: got %h %h want %h %h", cyc, bus.rsp0_result, bus.rsp1_result, lastRes[0], lastRes[1]); end
      eF = 0; eA = 0; eB = 0;
      if (mBusy && mAge == 0 && !mIllegal) begin eF = mFunc; eA = mA; eB = mB; end
      vecs++; if (int'(bus.alu_function) != eF || int'(bus.alu_a) != eA || int'(bus.alu_b) != eB) begin errs++; $display("FAIL rnd_alu_bus@%0d: got %0d %0d %0d want %0d %0d %0d", cyc, bus.alu_function, bus.alu_a, bus.alu_b, eF, eA, eB); end
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      if (vis) begin
        vecs++; if ((mOwner == 0 ? bus.rsp0_err : bus.rsp1_err) !== mIllegal) begin errs++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, mOwner == 0 ? bus.rsp0_err : bus.rsp1_err, mIllegal); end
      end
`endif
      for (int n = 0; n < 2; n++) begin
        if (!v[n]) begin
          v[n] = ($urandom_range(0, 2) != 0);
          f[n] = $urandom_range(0, 11); a[n] = $urandom_range(0, 255); b[n] = $urandom_range(0, 255);
          if ($urandom_range(0, 1) == 1) b[n] = b[n] % 8;
        end
        rr[n] = ($urandom_range(0, 3) != 0);
      end
      drive0(v[0], f[0], a[0], b[0]);
      drive1(v[1], f[1], a[1], b[1]);
      bus.rsp0_ready = rr[0];
      bus.rsp1_ready = rr[1];
      #1;
      anyWin = !mBusy && (v[0] || v[1]);
      winner = (v[0] && v[1]) ? 1 - mLast : (v[0] ? 0 : 1);
      vecs++; if (bus.req0_ready !== (anyWin && winner == 0) || bus.req1_ready !== (anyWin && winner == 1)) begin errs++; $display("FAIL rnd_ready@%0d: got %b%b want %b%b", cyc, bus.req1_ready, bus.req0_ready, anyWin && winner == 1, anyWin && winner == 0); end
      if (anyWin) begin
        mBusy = 1'b1; mOwner = winner; mLast = winner; mAge = 0;
        mFunc = f[winner]; mA = a[winner]; mB = b[winner];
`ifdef ALU_ILLEGAL_OP_CHECK_EN
        mIllegal = (mFunc == 0) || (mFunc > 9);
`else
        mIllegal = 1'b0;
`endif
        mRes = mIllegal ? 8'd0 : aluRef(mFunc, mA, mB);
        v[winner] = 1'b0;
      end else if (mBusy) begin
        if (vis && rr[mOwner]) mBusy = 1'b0;
        else if (mAge < 3) mAge++;
      end
      @(negedge clk);
    end
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive0(1'b0, 0, 0, 0);
    drive1(1'b0, 0, 0, 0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    test_reset();
    test_add_wrap();
    test_simultaneous();
    test_rotate();
    test_backpressure();
    test_reset_mid_issue();
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    test_illegal_op();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
